// File: rtl/toggle_activity_monitor.sv
`default_nettype none
// ============================================================================
// Module      : toggle_activity_monitor
// Description : Observes the Q outputs of a flip-flop bank and counts bit
//               transitions between consecutive valid samples over a
//               programmable window.  The baseline sample of each window
//               contributes no toggles.  The saturating total is returned
//               through a valid/ready handshake.
// Ports       : CLK, RST          - clock, synchronous active-high reset
//               START, WIN_LEN    - begin a window of WIN_LEN counted samples
//               Q_IN, Q_VALID     - observed flop outputs and sample strobe
//               RES_CNT, RES_VALID, RES_READY - result handshake
//               BUSY              - high while arming or counting
//               SAT               - accumulator saturated in this window
//               RISE_CNT, FALL_CNT - per-direction counts (TOGGLE_SPLIT_EN)
// Options     : define TOGGLE_SPLIT_EN to add the rise/fall count outputs
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_activity_monitor #(
  parameter int WIDTH    = 16,
  parameter int WIN_BITS = 16,
  parameter int CNT_BITS = 24
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [WIN_BITS-1:0] WIN_LEN,
  input  logic [WIDTH-1:0]    Q_IN,
  input  logic                Q_VALID,
  output logic [CNT_BITS-1:0] RES_CNT,
  output logic                RES_VALID,
  input  logic                RES_READY,
  output logic                BUSY,
  output logic                SAT
`ifdef TOGGLE_SPLIT_EN
  ,
  output logic [CNT_BITS-1:0] RISE_CNT,
  output logic [CNT_BITS-1:0] FALL_CNT
`endif
);

  // Popcount width, and an adder wide enough that neither operand overflows
  // before the saturation compare (popcount may be wider than CNT_BITS).
  localparam int c_PC_W  = $clog2(WIDTH + 1);
  localparam int c_SUM_W = ((CNT_BITS > c_PC_W) ? CNT_BITS : c_PC_W) + 1;
  localparam logic [c_SUM_W-1:0] c_MAX =
    {{(c_SUM_W - CNT_BITS){1'b0}}, {CNT_BITS{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_COUNT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_prev;
  logic [WIN_BITS-1:0] r_rem;
  logic [CNT_BITS-1:0] r_acc;
  logic                r_valid;
  logic                r_busy;
  logic                r_sat;

  function automatic logic [c_PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [c_PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + c_PC_W'(v[i]);
    end
    return n;
  endfunction

  // Returns {saturated, clamped sum}.
  function automatic logic [CNT_BITS:0] sat_add(input logic [CNT_BITS-1:0] acc,
                                                input logic [c_PC_W-1:0]   pc);
    logic [c_SUM_W-1:0] s;
    s = c_SUM_W'(acc) + c_SUM_W'(pc);
    if (s > c_MAX) begin
      return {1'b1, {CNT_BITS{1'b1}}};
    end
    return {1'b0, s[CNT_BITS-1:0]};
  endfunction

  logic [CNT_BITS:0] w_tot;
  assign w_tot = sat_add(r_acc, popcount(Q_IN ^ r_prev));

`ifdef TOGGLE_SPLIT_EN
  logic [CNT_BITS-1:0] r_rise;
  logic [CNT_BITS-1:0] r_fall;
  logic [CNT_BITS:0]   w_rise;
  logic [CNT_BITS:0]   w_fall;
  assign w_rise   = sat_add(r_rise, popcount(~r_prev & Q_IN));
  assign w_fall   = sat_add(r_fall, popcount(r_prev & ~Q_IN));
  assign RISE_CNT = r_rise;
  assign FALL_CNT = r_fall;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_prev  <= '0;
      r_rem   <= '0;
      r_acc   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_sat   <= 1'b0;
`ifdef TOGGLE_SPLIT_EN
      r_rise  <= '0;
      r_fall  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_rem <= WIN_LEN;
            r_acc <= '0;
            r_sat <= 1'b0;
`ifdef TOGGLE_SPLIT_EN
            r_rise <= '0;
            r_fall <= '0;
`endif
            if (WIN_LEN == '0) begin
              r_state <= S_DONE;
              r_valid <= 1'b1;
            end else begin
              r_state <= S_ARM;
              r_busy  <= 1'b1;
            end
          end
        end
        S_ARM: begin
          // Baseline sample: establishes prev, counts nothing.
          if (Q_VALID) begin
            r_prev  <= Q_IN;
            r_state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (Q_VALID) begin
            r_acc  <= w_tot[CNT_BITS-1:0];
            r_prev <= Q_IN;
            r_rem  <= r_rem - 1'b1;
`ifdef TOGGLE_SPLIT_EN
            r_rise <= w_rise[CNT_BITS-1:0];
            r_fall <= w_fall[CNT_BITS-1:0];
            r_sat  <= r_sat | w_tot[CNT_BITS] | w_rise[CNT_BITS] | w_fall[CNT_BITS];
`else
            r_sat  <= r_sat | w_tot[CNT_BITS];
`endif
            if (r_rem == WIN_BITS'(1)) begin
              r_state <= S_DONE;
              r_valid <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        S_DONE: begin
          // START here is deliberately ignored, even alongside the handshake.
          if (RES_READY) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign RES_CNT   = r_acc;
  assign RES_VALID = r_valid;
  assign BUSY      = r_busy;
  assign SAT       = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_toggle_activity_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_toggle_activity_monitor
// Description : Self-checking bench for toggle_activity_monitor.  A vector
//               table drives the default-size instance cycle by cycle; a
//               short hand sequence exercises a 4-bit accumulator instance
//               for saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_toggle_activity_monitor;

  logic        CLK;
  logic        RST, START, Q_VALID, RES_READY;
  logic [15:0] WIN_LEN, Q_IN;
  logic [23:0] RES_CNT;
  logic        RES_VALID, BUSY, SAT;

  logic        s_RST, s_START, s_Q_VALID, s_RES_READY;
  logic [15:0] s_WIN_LEN, s_Q_IN;
  logic [3:0]  s_RES_CNT;
  logic        s_RES_VALID, s_BUSY, s_SAT;

`ifdef TOGGLE_SPLIT_EN
  logic [23:0] RISE_CNT, FALL_CNT;
  logic [3:0]  s_RISE_CNT, s_FALL_CNT;
`endif

  int n_checks = 0;
  int n_errors = 0;

  toggle_activity_monitor #(.WIDTH(16), .WIN_BITS(16), .CNT_BITS(24)) u_dut (
    .CLK(CLK), .RST(RST), .START(START), .WIN_LEN(WIN_LEN), .Q_IN(Q_IN),
    .Q_VALID(Q_VALID), .RES_CNT(RES_CNT), .RES_VALID(RES_VALID),
    .RES_READY(RES_READY), .BUSY(BUSY), .SAT(SAT)
`ifdef TOGGLE_SPLIT_EN
    , .RISE_CNT(RISE_CNT), .FALL_CNT(FALL_CNT)
`endif
  );

  toggle_activity_monitor #(.WIDTH(16), .WIN_BITS(16), .CNT_BITS(4)) u_sat (
    .CLK(CLK), .RST(s_RST), .START(s_START), .WIN_LEN(s_WIN_LEN), .Q_IN(s_Q_IN),
    .Q_VALID(s_Q_VALID), .RES_CNT(s_RES_CNT), .RES_VALID(s_RES_VALID),
    .RES_READY(s_RES_READY), .BUSY(s_BUSY), .SAT(s_SAT)
`ifdef TOGGLE_SPLIT_EN
    , .RISE_CNT(s_RISE_CNT), .FALL_CNT(s_FALL_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst, start;
    logic [15:0] win;
    logic        qv;
    logic [15:0] q;
    logic        rdy;
    logic        ev, eb;
    logic [23:0] ec;
    logic        es;
    logic [23:0] er, ef;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic start, input logic [15:0] win,
                     input logic qv, input logic [15:0] q, input logic rdy,
                     input logic ev, input logic eb, input logic [23:0] ec,
                     input logic es, input logic [23:0] er, input logic [23:0] ef);
    vec_t v;
    v = '{rst, start, win, qv, q, rdy, ev, eb, ec, es, er, ef};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sstep(input logic rst, input logic start, input logic [15:0] win,
                       input logic qv, input logic [15:0] q, input logic rdy);
    @(negedge CLK);
    s_RST = rst; s_START = start; s_WIN_LEN = win;
    s_Q_VALID = qv; s_Q_IN = q; s_RES_READY = rdy;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; WIN_LEN = '0; Q_IN = '0; Q_VALID = 1'b0; RES_READY = 1'b0;
    s_RST = 1'b1; s_START = 1'b0; s_WIN_LEN = '0; s_Q_IN = '0; s_Q_VALID = 1'b0;
    s_RES_READY = 1'b0;

    // rst start win qv q rdy | valid busy cnt sat rise fall
    // Reset
    add(1, 0, 0, 0, 16'h0000, 0,  0, 0, 0,  0, 0,  0);
    add(0, 0, 0, 0, 16'h0000, 0,  0, 0, 0,  0, 0,  0);
    // Basic window, WIN_LEN altered after START to prove it is latched
    add(0, 1, 3, 0, 16'h0000, 0,  0, 1, 0,  0, 0,  0);
    add(0, 0, 1, 1, 16'h0000, 0,  0, 1, 0,  0, 0,  0);
    add(0, 0, 1, 1, 16'hFFFF, 0,  0, 1, 16, 0, 16, 0);
    add(0, 0, 1, 1, 16'h00FF, 0,  0, 1, 24, 0, 16, 8);
    add(0, 0, 1, 1, 16'h00FF, 0,  1, 0, 24, 0, 16, 8);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 16'h0000, 0,  1, 0, 24, 0, 16, 8);
    add(0, 0, 0, 0, 16'h0000, 1,  0, 0, 24, 0, 16, 8);
    add(0, 0, 0, 0, 16'h0000, 0,  0, 0, 24, 0, 16, 8);
    // Gaps between samples
    add(0, 1, 2, 0, 16'hFFFF, 0,  0, 1, 0,  0, 0,  0);
    add(0, 0, 2, 1, 16'h0001, 0,  0, 1, 0,  0, 0,  0);
    for (int i = 0; i < 3; i++) add(0, 0, 2, 0, 16'hFFFF, 0,  0, 1, 0, 0, 0, 0);
    add(0, 0, 2, 1, 16'h0003, 0,  0, 1, 1,  0, 1,  0);
    for (int i = 0; i < 3; i++) add(0, 0, 2, 0, 16'hFFFF, 0,  0, 1, 1, 0, 1, 0);
    add(0, 0, 2, 1, 16'h0002, 0,  1, 0, 2,  0, 1,  1);
    // START together with the DONE handshake is ignored
    add(0, 1, 2, 0, 16'h0000, 1,  0, 0, 2,  0, 1,  1);
    add(0, 0, 2, 0, 16'h0000, 0,  0, 0, 2,  0, 1,  1);
    // Zero-length window
    add(0, 1, 0, 0, 16'h0000, 0,  1, 0, 0,  0, 0,  0);
    add(0, 0, 0, 0, 16'h0000, 0,  1, 0, 0,  0, 0,  0);
    add(0, 0, 0, 0, 16'h0000, 1,  0, 0, 0,  0, 0,  0);
    // START during COUNT is ignored (a zero window would end it at once)
    add(0, 1, 1, 0, 16'h0000, 0,  0, 1, 0,  0, 0,  0);
    add(0, 0, 1, 1, 16'h1234, 0,  0, 1, 0,  0, 0,  0);
    add(0, 1, 0, 0, 16'h0000, 0,  0, 1, 0,  0, 0,  0);
    add(0, 0, 0, 1, 16'h1235, 0,  1, 0, 1,  0, 1,  0);
    add(0, 0, 0, 0, 16'h0000, 1,  0, 0, 1,  0, 1,  0);
    // Reset in the middle of COUNT
    add(0, 1, 3, 0, 16'h0000, 0,  0, 1, 0,  0, 0,  0);
    add(0, 0, 3, 1, 16'h0000, 0,  0, 1, 0,  0, 0,  0);
    add(0, 0, 3, 1, 16'hFFFF, 0,  0, 1, 16, 0, 16, 0);
    add(1, 0, 3, 1, 16'h0000, 0,  0, 0, 0,  0, 0,  0);
    add(1, 0, 3, 1, 16'h0000, 0,  0, 0, 0,  0, 0,  0);
    add(0, 0, 0, 0, 16'h0000, 1,  0, 0, 0,  0, 0,  0);
    add(0, 0, 0, 1, 16'hAAAA, 0,  0, 0, 0,  0, 0,  0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      RST = vecs[i].rst; START = vecs[i].start; WIN_LEN = vecs[i].win;
      Q_VALID = vecs[i].qv; Q_IN = vecs[i].q; RES_READY = vecs[i].rdy;
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d RES_VALID", i), 32'(RES_VALID), 32'(vecs[i].ev));
      chk($sformatf("v%0d BUSY", i),      32'(BUSY),      32'(vecs[i].eb));
      chk($sformatf("v%0d RES_CNT", i),   32'(RES_CNT),   32'(vecs[i].ec));
      chk($sformatf("v%0d SAT", i),       32'(SAT),       32'(vecs[i].es));
`ifdef TOGGLE_SPLIT_EN
      chk($sformatf("v%0d RISE_CNT", i),  32'(RISE_CNT),  32'(vecs[i].er));
      chk($sformatf("v%0d FALL_CNT", i),  32'(FALL_CNT),  32'(vecs[i].ef));
`endif
    end

    // Saturation with a 4-bit accumulator
    sstep(1, 0, 0, 0, 16'h0000, 0);
    sstep(0, 1, 2, 0, 16'h0000, 0);
    chk("sat arm BUSY", 32'(s_BUSY), 32'd1);
    sstep(0, 0, 2, 1, 16'h0000, 0);
    sstep(0, 0, 2, 1, 16'hFFFF, 0);
    chk("sat first RES_CNT", 32'(s_RES_CNT), 32'd15);
    chk("sat first SAT", 32'(s_SAT), 32'd1);
    sstep(0, 0, 2, 1, 16'h0000, 0);
    chk("sat done RES_VALID", 32'(s_RES_VALID), 32'd1);
    chk("sat done RES_CNT", 32'(s_RES_CNT), 32'd15);
    chk("sat done SAT", 32'(s_SAT), 32'd1);
`ifdef TOGGLE_SPLIT_EN
    chk("sat done RISE_CNT", 32'(s_RISE_CNT), 32'd15);
    chk("sat done FALL_CNT", 32'(s_FALL_CNT), 32'd15);
`endif
    sstep(0, 0, 0, 0, 16'h0000, 1);
    chk("sat idle RES_VALID", 32'(s_RES_VALID), 32'd0);
    chk("sat idle SAT held", 32'(s_SAT), 32'd1);
    sstep(0, 1, 1, 0, 16'h0000, 0);
    chk("sat restart SAT cleared", 32'(s_SAT), 32'd0);
    chk("sat restart RES_CNT cleared", 32'(s_RES_CNT), 32'd0);
    sstep(0, 0, 1, 1, 16'h0000, 0);
    sstep(0, 0, 1, 1, 16'h0001, 0);
    chk("sat second RES_VALID", 32'(s_RES_VALID), 32'd1);
    chk("sat second RES_CNT", 32'(s_RES_CNT), 32'd1);
    chk("sat second SAT", 32'(s_SAT), 32'd0);
`ifdef TOGGLE_SPLIT_EN
    chk("sat second RISE_CNT", 32'(s_RISE_CNT), 32'd1);
    chk("sat second FALL_CNT", 32'(s_FALL_CNT), 32'd0);
`endif
    sstep(0, 0, 0, 0, 16'h0000, 1);
    chk("sat final RES_VALID", 32'(s_RES_VALID), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
